// File: rtl/dbg_monitor.sv
// dbg_monitor: probe snapshot, multiplexed hex display scan, and core
// clock-enable generation (free-run or debounced single-step).
module dbg_monitor #(
  parameter int NUM_CH   = 16,
  parameter int CH_W     = 32,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 16,
  parameter int DEB_CYC  = 100000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH*CH_W-1:0]    probe_bus,
  input  logic [$clog2(NUM_CH)-1:0] sel,
  input  logic                      freeze,
  input  logic                      run_mode,
  input  logic                      step_btn,
  output logic                      cpu_ce,
  output logic [7:0]                leds,
  output logic [DIGITS-1:0]         anodes,
  output logic [6:0]                seg
);

  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_WAIT = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_REL_WAIT   = 2'd3
  } deb_state_t;

  // Active-low seven-segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      4'hF:    pat = 7'h0E;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  logic [CH_W-1:0]     snap_q, snap_d, chan_s;
  logic [SCAN_DIV-1:0] scan_q, scan_d;
  logic [DIG_W-1:0]    dig_s;
  logic [DIGITS-1:0]   anodes_q, anodes_d;
  logic [6:0]          seg_q, seg_d;
  logic [1:0]          sync_q, sync_d;
  logic                btn_s;
  deb_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                step_evt_s;
  logic                cpu_ce_q, cpu_ce_d;
  logic [15:0]         step_cnt_q, step_cnt_d;

  // Select the probe channel; out-of-range selects read as zero; freeze holds.
  always_comb begin
    chan_s = '0;
    if (int'(sel) < NUM_CH) begin
      chan_s = probe_bus[int'(sel)*CH_W +: CH_W];
    end else begin
      chan_s = '0;
    end
    if (freeze) begin
      snap_d = snap_q;
    end else begin
      snap_d = chan_s;
    end
  end

  // Free-running scan counter; its top bits pick the digit driven next cycle.
  always_comb begin
    scan_d   = scan_q + SCAN_DIV'(1);
    dig_s    = scan_q[SCAN_DIV-1 -: DIG_W];
    anodes_d = '1;
    seg_d    = 7'h7F;
    if (int'(dig_s) < DIGITS) begin
      anodes_d[dig_s] = 1'b0;
      seg_d           = hex7(snap_q[int'(dig_s)*4 +: 4]);
    end else begin
      anodes_d = '1;
      seg_d    = 7'h7F;
    end
  end

  // Two-flop synchroniser for the raw push button.
  always_comb begin
    sync_d = {sync_q[0], step_btn};
    btn_s  = sync_q[1];
  end

  // Debounce FSM: a level must hold DEB_CYC cycles; one event per accepted press.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    step_evt_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_PRESSED;
          step_evt_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!btn_s) begin
          state_d = ST_REL_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = ST_PRESSED;
        end
      end
      ST_REL_WAIT: begin
        if (btn_s) begin
          state_d = ST_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Clock-enable selection and the count of enabled core cycles.
  always_comb begin
    if (run_mode) begin
      cpu_ce_d = 1'b1;
    end else begin
      cpu_ce_d = step_evt_s;
    end
    if (cpu_ce_q) begin
      step_cnt_d = step_cnt_q + 16'd1;
    end else begin
      step_cnt_d = step_cnt_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_q     <= '0;
      scan_q     <= '0;
      anodes_q   <= '1;
      seg_q      <= 7'h7F;
      sync_q     <= 2'b00;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cpu_ce_q   <= 1'b0;
      step_cnt_q <= 16'd0;
    end else begin
      snap_q     <= snap_d;
      scan_q     <= scan_d;
      anodes_q   <= anodes_d;
      seg_q      <= seg_d;
      sync_q     <= sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cpu_ce_q   <= cpu_ce_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign cpu_ce = cpu_ce_q;
  assign leds   = step_cnt_q[7:0];
  assign anodes = anodes_q;
  assign seg    = seg_q;

endmodule
